// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the instruction/data requester handshakes and the single RAM port
//   that mem_arbiter multiplexes between them.
//
//   Signals
//     iREN/iaddr          instruction read request and address
//     iload/iwait         instruction read data and hold
//     dREN/dWEN           data read/write requests
//     daddr/dstore        data address and write value
//     dload/dwait         data read data and hold
//     ramREN/ramWEN       RAM read/write enables
//     ramaddr/ramstore    RAM address and write data
//     ramload/ramstate    RAM read data and status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
//
//   Modports
//     slave   arbiter view (consumes requests and RAM status, drives the rest)
//     master  environment view (cache-side requesters plus RAM model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported RAM between the instruction-fetch and data-access
//   requesters. Data has priority; a streak counter forces an instruction grant
//   after DSTREAK_MAX back-to-back data grants while iREN waits. Repeated RAM
//   ERROR responses are retried up to RETRY_MAX per transaction, after which the
//   transaction completes with zero data and the sticky fault flag is raised.
//
//   Ports
//     CLK      system clock
//     nRST     asynchronous active-low reset
//     bus      mem_arbiter_if.slave: requester handshakes and RAM port
//     fault    sticky retry-exhaustion flag
//     grant_d  high while the data side owns the RAM
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned DSTREAK_MAX = 4,
    parameter int unsigned RETRY_MAX   = 3
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus,
    output logic          fault,
    output logic          grant_d
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam int unsigned SW = $clog2(DSTREAK_MAX + 1);
    localparam int unsigned RW = $clog2(RETRY_MAX + 1);

    localparam logic [SW-1:0] STREAK_LIMIT = SW'(DSTREAK_MAX);
    // Retry count at which the next ERROR exhausts the budget.
    localparam logic [RW-1:0] RETRY_LAST   = RW'(RETRY_MAX - 1);

    logic [1:0]    state_q,  state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [RW-1:0] retry_q,  retry_d;
    logic          fault_q,  fault_d;

    logic          dreq;
    logic          own_req;
    logic          done;
    logic          fault_now;
    logic [31:0]   load_val;

    assign dreq = bus.dREN | bus.dWEN;

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        retry_d   = retry_q;
        fault_d   = fault_q;
        own_req   = 1'b0;
        done      = 1'b0;
        fault_now = 1'b0;
        load_val  = '0;

        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.iwait    = bus.iREN;
        bus.dwait    = dreq;

        case (state_q)
            IDLE: begin
                // Streak only grows while the instruction side is actually
                // being held off; an idle iREN means no one is starving.
                if (dreq && !(bus.iREN && streak_q == STREAK_LIMIT)) begin
                    state_d  = GNT_D;
                    streak_d = bus.iREN ? streak_q + 1'b1 : '0;
                end else if (bus.iREN) begin
                    state_d  = GNT_I;
                    streak_d = '0;
                end
            end

            GNT_I, GNT_D: begin
                own_req = (state_q == GNT_I) ? bus.iREN : dreq;
                if (!own_req) begin
                    // Owner withdrew: release the RAM without a handshake.
                    state_d = IDLE;
                    retry_d = '0;
                end else begin
                    if (state_q == GNT_I) begin
                        bus.ramREN  = 1'b1;
                        bus.ramaddr = bus.iaddr;
                    end else begin
                        bus.ramWEN   = bus.dWEN;
                        bus.ramREN   = bus.dREN & ~bus.dWEN;
                        bus.ramaddr  = bus.daddr;
                        bus.ramstore = bus.dstore;
                    end

                    case (bus.ramstate)
                        RS_ACCESS: begin
                            done     = 1'b1;
                            load_val = bus.ramload;
                        end
                        RS_ERROR: begin
                            if (retry_q == RETRY_LAST) begin
                                done      = 1'b1;
                                fault_now = 1'b1;
                                fault_d   = 1'b1;
                            end else begin
                                retry_d = retry_q + 1'b1;
                            end
                        end
                        RS_FREE, RS_BUSY: ;
                        default: ;
                    endcase

                    if (done) begin
                        state_d = IDLE;
                        retry_d = '0;
                        if (state_q == GNT_I) begin
                            bus.iwait = 1'b0;
                            bus.iload = load_val;
                        end else begin
                            bus.dwait = 1'b0;
                            bus.dload = load_val;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // The exhausting ERROR cycle already reports the fault.
    assign fault   = fault_q | fault_now;
    assign grant_d = (state_q == GNT_D);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
            retry_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            retry_q  <= retry_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Inputs change 1 time unit after each rising
//   edge; outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic CLK;
    logic nRST;
    logic fault;
    logic grant_d;

    int unsigned errors;
    int unsigned checks;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .DSTREAK_MAX (4),
        .RETRY_MAX   (3)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .bus     (bus.slave),
        .fault   (fault),
        .grant_d (grant_d)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nRST = 1'b1;
        bus.iREN = 1'b0;  bus.iaddr = '0;
        bus.dREN = 1'b0;  bus.dWEN = 1'b0;  bus.daddr = '0;  bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;

        // ---------------- reset ----------------
        #1 nRST = 1'b0;
        bus.iREN = 1'b1;
        #1;
        chk("rst_iwait",   {31'd0, bus.iwait},  32'd1);
        chk("rst_dwait",   {31'd0, bus.dwait},  32'd0);
        chk("rst_ramREN",  {31'd0, bus.ramREN}, 32'd0);
        chk("rst_ramWEN",  {31'd0, bus.ramWEN}, 32'd0);
        chk("rst_ramaddr", bus.ramaddr,         32'd0);
        chk("rst_ramstore",bus.ramstore,        32'd0);
        chk("rst_iload",   bus.iload,           32'd0);
        chk("rst_fault",   {31'd0, fault},      32'd0);
        chk("rst_grant_d", {31'd0, grant_d},    32'd0);
        bus.iREN = 1'b0;
        #10 nRST = 1'b1;

        // ---------------- single instruction read ----------------
        cyc; bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
        smp; chk("rd_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
             chk("rd_idle_iwait",  {31'd0, bus.iwait},  32'd1);
        cyc; smp;
        chk("rd_gnt_ramREN",  {31'd0, bus.ramREN}, 32'd1);
        chk("rd_gnt_ramaddr", bus.ramaddr,         32'h40);
        chk("rd_busy1_iwait", {31'd0, bus.iwait},  32'd1);
        cyc; smp;
        chk("rd_busy2_iwait", {31'd0, bus.iwait},  32'd1);
        cyc; bus.ramstate = ACCESS; bus.ramload = 32'h3C010001;
        smp;
        chk("rd_acc_iwait", {31'd0, bus.iwait}, 32'd0);
        chk("rd_acc_iload", bus.iload,          32'h3C010001);
        chk("rd_acc_dload", bus.dload,          32'd0);
        cyc; bus.iREN = 1'b0; bus.ramstate = FREE;
        smp;
        chk("rd_done_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("rd_done_iwait",  {31'd0, bus.iwait},  32'd0);

        // ---------------- simultaneous request: data first ----------------
        cyc; bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h200;
        smp; chk("cf_idle_grant_d", {31'd0, grant_d}, 32'd0);
        cyc; smp;
        chk("cf_gd_grant_d", {31'd0, grant_d},    32'd1);
        chk("cf_gd_ramaddr", bus.ramaddr,         32'h200);
        chk("cf_gd_iwait",   {31'd0, bus.iwait},  32'd1);
        chk("cf_gd_dwait",   {31'd0, bus.dwait},  32'd1);
        cyc; bus.ramstate = ACCESS; bus.ramload = 32'h11112222;
        smp;
        chk("cf_d_dwait", {31'd0, bus.dwait}, 32'd0);
        chk("cf_d_dload", bus.dload,          32'h11112222);
        chk("cf_d_iload", bus.iload,          32'd0);
        cyc; bus.dREN = 1'b0; bus.ramstate = FREE;
        smp;
        chk("cf_idle2_grant_d", {31'd0, grant_d},    32'd0);
        chk("cf_idle2_ramREN",  {31'd0, bus.ramREN}, 32'd0);
        chk("cf_idle2_iwait",   {31'd0, bus.iwait},  32'd1);
        cyc; bus.ramstate = ACCESS; bus.ramload = 32'h00000055;
        smp;
        chk("cf_i_ramaddr", bus.ramaddr,         32'h44);
        chk("cf_i_iwait",   {31'd0, bus.iwait},  32'd0);
        chk("cf_i_iload",   bus.iload,           32'h55);
        cyc; bus.iREN = 1'b0; bus.ramstate = FREE;

        // ---------------- starvation bound ----------------
        cyc; bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h300;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                smp; chk("sv_idle_grant_d", {31'd0, grant_d}, 32'd0);
                cyc; bus.ramstate = ACCESS; bus.ramload = 32'h1000 + 32'(k);
                smp;
                chk("sv_d_grant_d", {31'd0, grant_d},   32'd1);
                chk("sv_d_dwait",   {31'd0, bus.dwait}, 32'd0);
                chk("sv_d_iwait",   {31'd0, bus.iwait}, 32'd1);
                cyc; bus.ramstate = FREE;
            end
            smp; chk("sv_idle5_grant_d", {31'd0, grant_d}, 32'd0);
            cyc; bus.ramstate = ACCESS; bus.ramload = 32'h2000;
            smp;
            chk("sv_i_grant_d", {31'd0, grant_d},   32'd0);
            chk("sv_i_ramaddr", bus.ramaddr,        32'h80);
            chk("sv_i_iwait",   {31'd0, bus.iwait}, 32'd0);
            chk("sv_i_dwait",   {31'd0, bus.dwait}, 32'd1);
            cyc; bus.ramstate = FREE;
        end
        bus.iREN = 1'b0; bus.dREN = 1'b0;

        // ---------------- write wins over read ----------------
        cyc; bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        cyc; bus.ramstate = BUSY;
        smp;
        chk("wr_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
        chk("wr_ramREN",   {31'd0, bus.ramREN}, 32'd0);
        chk("wr_ramstore", bus.ramstore,        32'hDEADBEEF);
        chk("wr_ramaddr",  bus.ramaddr,         32'h100);
        chk("wr_busy_dwait", {31'd0, bus.dwait}, 32'd1);
        cyc; bus.ramstate = ACCESS;
        smp; chk("wr_acc_dwait", {31'd0, bus.dwait}, 32'd0);
        cyc; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;

        // ---------------- retry exhaustion ----------------
        cyc; bus.dREN = 1'b1; bus.daddr = 32'h300;
        cyc; bus.ramstate = ERROR; bus.ramload = 32'hAAAA5555;
        smp;
        chk("er1_fault",  {31'd0, fault},      32'd0);
        chk("er1_dwait",  {31'd0, bus.dwait},  32'd1);
        chk("er1_ramREN", {31'd0, bus.ramREN}, 32'd1);
        cyc; smp;
        chk("er2_fault",  {31'd0, fault},      32'd0);
        chk("er2_dwait",  {31'd0, bus.dwait},  32'd1);
        cyc; smp;
        chk("er3_fault",  {31'd0, fault},      32'd1);
        chk("er3_dwait",  {31'd0, bus.dwait},  32'd0);
        chk("er3_dload",  bus.dload,           32'd0);
        cyc; bus.ramstate = FREE;
        smp;
        chk("er_idle_fault",   {31'd0, fault},   32'd1);
        chk("er_idle_grant_d", {31'd0, grant_d}, 32'd0);
        cyc; bus.ramstate = ACCESS; bus.ramload = 32'h00001234;
        smp;
        chk("er_ok_dload", bus.dload,     32'h1234);
        chk("er_ok_fault", {31'd0, fault}, 32'd1);
        cyc; bus.dREN = 1'b0; bus.ramstate = FREE;
        smp; chk("er_sticky_fault", {31'd0, fault}, 32'd1);

        // ---------------- abort ----------------
        cyc; bus.dREN = 1'b1; bus.daddr = 32'h400;
        cyc; bus.ramstate = BUSY;
        smp; chk("ab_grant_d", {31'd0, grant_d}, 32'd1);
        cyc; bus.dREN = 1'b0; bus.ramstate = ACCESS; bus.ramload = 32'h77777777;
        smp;
        chk("ab_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("ab_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        chk("ab_dload",  bus.dload,           32'd0);
        chk("ab_dwait",  {31'd0, bus.dwait},  32'd0);
        cyc; bus.ramstate = FREE;
        smp;
        chk("ab_idle_grant_d", {31'd0, grant_d},    32'd0);
        chk("ab_idle_ramREN",  {31'd0, bus.ramREN}, 32'd0);

        // ---------------- reset while instruction granted ----------------
        cyc; bus.iREN = 1'b1; bus.iaddr = 32'h500;
        cyc; bus.ramstate = BUSY;
        smp; chk("rg_ramREN", {31'd0, bus.ramREN}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("rg_rst_ramREN",  {31'd0, bus.ramREN}, 32'd0);
        chk("rg_rst_ramaddr", bus.ramaddr,         32'd0);
        chk("rg_rst_iwait",   {31'd0, bus.iwait},  32'd1);
        chk("rg_rst_fault",   {31'd0, fault},      32'd0);
        #1 nRST = 1'b1;
        #1;
        chk("rg_rel_ramREN", {31'd0, bus.ramREN}, 32'd0);
        cyc; bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
        smp;
        chk("rg_gnt_ramaddr", bus.ramaddr,        32'h500);
        chk("rg_gnt_iload",   bus.iload,          32'hCAFEF00D);
        chk("rg_gnt_iwait",   {31'd0, bus.iwait}, 32'd0);
        cyc; bus.iREN = 1'b0; bus.ramstate = FREE;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
